bft_leaf_intf: RTL and testbench
================================

// Module: bft_leaf_intf
// PURPOSE
//  Leaf-side adapter between one PE and one leaf port of the 8-leaf butterfly-fat-tree (BFT) network.
//  TX path:
//   - accepts valid/ready beats {dest, payload} from the PE;
//   - builds 49-bit packets {valid, dest[2:0], payload[44:0]} and drives them onto the network's dout_leaf input;
//   - holds and re-presents a packet while the network asserts resend.
//  RX path:
//   - buffers packets arriving on the network's din_leaf output into a small FIFO;
//   - presents them to the PE with valid/ready.
// PARAMETERS
//  PAYLOAD_SZ  45  payload bits per packet
//  ADDR_SZ     3   destination leaf address bits (log2 of 8 leaves)
//  P_SZ        49  packet width = 1 + ADDR_SZ + PAYLOAD_SZ
//  TX_DEPTH    4   TX FIFO entries (power of 2)
//  RX_DEPTH    4   RX FIFO entries (power of 2)
//  CNT_W       16  retry counter width
// PORTS
//  clk           in   1           clock
//  reset         in   1           asynchronous, active-low reset
//  s_valid       in   1           PE TX beat valid
//  s_ready       out  1           TX FIFO can accept
//  s_dest        in   ADDR_SZ     destination leaf
//  s_payload     in   PAYLOAD_SZ  TX payload
//  dout_leaf     out  P_SZ        packet to network; bit P_SZ-1 = valid
//  resend        in   1           network rejected the dout_leaf packet this cycle
//  din_leaf      in   P_SZ        packet from network; bit P_SZ-1 = valid
//  m_valid       out  1           RX beat valid
//  m_ready       in   1           PE accepts RX beat
//  m_payload     out  PAYLOAD_SZ  RX payload (din_leaf[PAYLOAD_SZ-1:0])
//  rx_overflow   out  1           sticky: an RX packet was dropped
//  tx_retry_cnt  out  CNT_W       number of cycles with dout_leaf valid and resend high
//  clear_stats   in   1           sync clear of rx_overflow and tx_retry_cnt
// BEHAVIOUR
//  Reset (reset=0, async):
//   - FIFOs empty; dout_leaf=0; m_valid=0; s_ready=1 once released.
//   - rx_overflow=0; tx_retry_cnt=0. Reset mid-transfer discards all queued packets.
//  TX FIFO:
//   - push when s_valid & s_ready; s_ready = (tx_count != TX_DEPTH), from registered count.
//   - at full with a same-cycle pop, s_ready stays 0; the freed slot is visible next cycle.
//  TX output register (OUT), states IDLE / SEND:
//   - IDLE (dout_leaf valid=0), FIFO non-empty: load head {1,dest,payload}, pop -> SEND.
//   - SEND, resend=0: packet consumed this edge. If FIFO non-empty, load next head and stay in SEND
//     (back-to-back, one packet/cycle); else clear dout_leaf to 0 -> IDLE.
//   - SEND, resend=1: hold dout_leaf unchanged, no pop, tx_retry_cnt++.
//   - Latency: beat accepted in cycle t with TX empty and OUT in IDLE appears on dout_leaf in cycle t+2.
//   - resend while in IDLE is ignored (no count).
//   - dest equal to this leaf's own address is not checked; routing is the network's concern.
//  RX FIFO:
//   - pushed at an edge where din_leaf[P_SZ-1]=1; address field discarded.
//   - m_valid = (rx_count != 0); pop on m_valid & m_ready; head on m_payload.
//   - Full with a same-cycle pop: incoming packet is accepted.
//   - Full with no pop: incoming packet is dropped and rx_overflow is set.
//   - RX FIFO is never back-pressured to the network.
//  Stats:
//   - tx_retry_cnt saturates at all-ones.
//   - clear_stats wins over a same-cycle increment or overflow set; both outputs are 0 the next cycle.
//  Pointers wrap modulo depth; one extra count bit distinguishes full from empty.
// TESTING
//  1. Reset -> s_ready=1, dout_leaf=0, m_valid=0, rx_overflow=0, tx_retry_cnt=0.
//  2. Push dest=5, payload=0x1ABC at t, resend=0 -> dout_leaf=49'h1_5_..._1ABC at t+2 only, then 0.
//  3. Push 4 beats back-to-back, resend=0 -> 4 consecutive packets on dout_leaf, in order.
//  4. Push A,B; resend=1 for 3 cycles while A shows -> A held 4 cycles, then B, tx_retry_cnt=3.
//  5. Hold resend=1, push 5 beats -> s_ready=0 after the TX FIFO (4) is full; OUT holds the 5th; no loss.
//  6. m_ready=0, 5 valid din_leaf packets -> 4 buffered, 5th dropped, rx_overflow=1;
//     drain -> payloads 1..4 in order; clear_stats -> rx_overflow=0.

Source files
------------

// File: rtl/bft_leaf_intf.sv
// ---------------------------------------------------------------------------
// bft_leaf_intf
//   Leaf-side adapter between one PE and one leaf port of an 8-leaf
//   butterfly-fat-tree network.
//
//   TX: PE beats {dest, payload} go into a small FIFO. An output register
//       then presents them on dout_leaf as {valid, dest, payload}. While the
//       network raises resend, the packet on dout_leaf is held and each such
//       cycle is counted in tx_retry_cnt (the counter saturates).
//   RX: valid packets on din_leaf go into a small FIFO and are handed to the
//       PE with valid/ready. The network is never back-pressured, so a
//       packet that arrives while the FIFO is full (and nothing pops) is
//       dropped, and the sticky rx_overflow flag is set.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   s_valid/s_ready            PE TX handshake
//   s_dest, s_payload          PE TX beat
//   dout_leaf                  packet to network, MSB = valid
//   resend                     network rejected dout_leaf this cycle
//   din_leaf                   packet from network, MSB = valid
//   m_valid/m_ready, m_payload PE RX handshake and data
//   rx_overflow                sticky RX drop flag
//   tx_retry_cnt               saturating count of rejected send cycles
//   clear_stats                synchronous clear of rx_overflow/tx_retry_cnt
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// bft_leaf_fifo
//   Register-array FIFO with combinational head read. Each pointer carries
//   one extra wrap bit, so count = wr_ptr - rd_ptr tells full from empty.
//   The caller guards push/pop. When the FIFO is full, a push is legal only
//   together with a pop: the head is read before the edge, and the slot is
//   overwritten at the edge.
//
// Ports
//   clk, reset   clock, asynchronous active-low reset
//   push, wdata  write enable and data
//   pop, rdata   read enable and head data
//   count        occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module bft_leaf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4    // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: it is only ever observed through count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
endmodule

module bft_leaf_intf #(
    parameter int PAYLOAD_SZ = 45,
    parameter int ADDR_SZ    = 3,
    parameter int P_SZ       = 1 + ADDR_SZ + PAYLOAD_SZ,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_SZ-1:0]    s_dest,
    input  logic [PAYLOAD_SZ-1:0] s_payload,
    output logic [P_SZ-1:0]       dout_leaf,
    input  logic                  resend,
    input  logic [P_SZ-1:0]       din_leaf,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PAYLOAD_SZ-1:0] m_payload,
    output logic                  rx_overflow,
    output logic [CNT_W-1:0]      tx_retry_cnt,
    input  logic                  clear_stats
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    typedef struct packed {
        logic [ADDR_SZ-1:0]    dest;
        logic [PAYLOAD_SZ-1:0] payload;
    } tx_beat_t;

    typedef enum logic {IDLE, SEND} out_state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    tx_beat_t       tx_wbeat;
    tx_beat_t       tx_head;
    logic [TX_AW:0] tx_count;
    logic           tx_push;
    logic           tx_pop;
    logic           tx_nonempty;
    out_state_t     state;

    assign tx_wbeat    = '{dest: s_dest, payload: s_payload};
    // s_ready comes only from the registered count. When the FIFO is full,
    // a same-cycle pop frees a slot that becomes visible one cycle later.
    assign s_ready     = (tx_count != (TX_AW+1)'(TX_DEPTH));
    assign tx_push     = s_valid & s_ready;
    assign tx_nonempty = (tx_count != '0);
    // The head moves into OUT when OUT is empty, or when the packet in OUT
    // is consumed this edge (SEND without resend).
    assign tx_pop      = tx_nonempty & ((state == IDLE) | ~resend);

    bft_leaf_fifo #(
        .W     ($bits(tx_beat_t)),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_wbeat),
        .rdata (tx_head),
        .count (tx_count)
    );

    // ------------------------------------------------------------------
    // TX output register. dout_leaf is driven straight from this register.
    // resend has meaning only in SEND, where the packet on the wire is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dout_leaf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_nonempty) begin
                        dout_leaf <= {1'b1, tx_head};
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (!resend) begin
                        if (tx_nonempty) begin
                            dout_leaf <= {1'b1, tx_head};   // back-to-back
                        end else begin
                            dout_leaf <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    dout_leaf <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO. The address field of din_leaf is not needed at the leaf.
    // ------------------------------------------------------------------
    logic                  rx_in_vld;
    logic                  rx_full;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_drop;
    logic [RX_AW:0]        rx_count;
    logic [PAYLOAD_SZ-1:0] rx_head;
    logic                  unused_rx_addr;

    assign rx_in_vld      = din_leaf[P_SZ-1];
    assign unused_rx_addr = ^din_leaf[P_SZ-2:PAYLOAD_SZ];
    assign rx_full        = (rx_count == (RX_AW+1)'(RX_DEPTH));
    assign m_valid        = (rx_count != '0);
    assign m_payload      = rx_head;
    assign rx_pop         = m_valid & m_ready;
    // A pop in the same cycle makes room, even when the FIFO is full.
    assign rx_push        = rx_in_vld & (~rx_full | rx_pop);
    assign rx_drop        = rx_in_vld & rx_full & ~rx_pop;

    bft_leaf_fifo #(
        .W     (PAYLOAD_SZ),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (din_leaf[PAYLOAD_SZ-1:0]),
        .rdata (rx_head),
        .count (rx_count)
    );

    // ------------------------------------------------------------------
    // Statistics. If clear_stats and an update land on the same edge,
    // the clear wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_retry_cnt <= '0;
            rx_overflow  <= 1'b0;
        end else if (clear_stats) begin
            tx_retry_cnt <= '0;
            rx_overflow  <= 1'b0;
        end else begin
            if ((state == SEND) && resend && (tx_retry_cnt != '1))
                tx_retry_cnt <= tx_retry_cnt + 1'b1;
            if (rx_drop)
                rx_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bft_leaf_intf.sv
module tb_bft_leaf_intf;
    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  s_dest;
    logic [44:0] s_payload;
    logic [48:0] dout_leaf;
    logic        resend;
    logic [48:0] din_leaf;
    logic        m_valid;
    logic        m_ready;
    logic [44:0] m_payload;
    logic        rx_overflow;
    logic [15:0] tx_retry_cnt;
    logic        clear_stats;

    int ncmp  = 0;
    int nfail = 0;

    bft_leaf_intf dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_dest       (s_dest),
        .s_payload    (s_payload),
        .dout_leaf    (dout_leaf),
        .resend       (resend),
        .din_leaf     (din_leaf),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_payload    (m_payload),
        .rx_overflow  (rx_overflow),
        .tx_retry_cnt (tx_retry_cnt),
        .clear_stats  (clear_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] pkt(input logic [2:0] d, input logic [44:0] p);
        return {1'b1, d, p};
    endfunction

    logic [48:0] exp_pkt;

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_dest = '0; s_payload = '0;
        resend = 1'b0; din_leaf = '0; m_ready = 1'b0; clear_stats = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_dout", 64'(dout_leaf), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_ovf", 64'(rx_overflow), 64'd0);
        chk("rst_retry", 64'(tx_retry_cnt), 64'd0);
        reset = 1'b1;
        tick();

        // ---- single packet latency: visible only in cycle t+2 ----
        s_valid = 1'b1; s_dest = 3'd5; s_payload = 45'h1ABC;
        chk("lat_s_ready", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        chk("lat_t1", 64'(dout_leaf), 64'd0);
        tick();
        chk("lat_t2", 64'(dout_leaf), 64'h1_A000_0000_1ABC);
        tick();
        chk("lat_t3", 64'(dout_leaf), 64'd0);

        // ---- four back-to-back beats ----
        for (int k = 0; k < 7; k++) begin
            s_valid   = (k < 4);
            s_dest    = 3'(k);
            s_payload = 45'(32'h100 + k);
            if (k < 4) chk("b2b_ready", 64'(s_ready), 64'd1);
            exp_pkt = (k >= 2 && k <= 5) ? pkt(3'(k-2), 45'(32'h100 + k - 2)) : '0;
            chk("b2b_dout", 64'(dout_leaf), 64'(exp_pkt));
            tick();
        end

        // ---- A held for 3 resend cycles, then B ----
        for (int k = 0; k < 8; k++) begin
            s_valid   = (k < 2);
            s_dest    = (k == 0) ? 3'd2 : 3'd7;
            s_payload = (k == 0) ? 45'hAAAA : 45'hBBBB;
            resend    = (k >= 2 && k <= 4);
            if (k >= 2 && k <= 5)  exp_pkt = pkt(3'd2, 45'hAAAA);
            else if (k == 6)       exp_pkt = pkt(3'd7, 45'hBBBB);
            else                   exp_pkt = '0;
            chk("hold_dout", 64'(dout_leaf), 64'(exp_pkt));
            if (k == 6) chk("hold_retry", 64'(tx_retry_cnt), 64'd3);
            tick();
        end
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clr_retry", 64'(tx_retry_cnt), 64'd0);

        // ---- resend held: TX FIFO fills, nothing lost ----
        for (int k = 0; k < 12; k++) begin
            s_valid   = (k <= 6);
            s_dest    = 3'(k);
            s_payload = 45'(32'h500 + ((k > 5) ? 5 : k));
            resend    = (k <= 5);
            if (k <= 4)      chk("full_ready", 64'(s_ready), 64'd1);
            else if (k <= 6) chk("full_ready0", 64'(s_ready), 64'd0);
            else if (k == 7) chk("full_ready1", 64'(s_ready), 64'd1);
            if (k >= 2 && k <= 6)       exp_pkt = pkt(3'd0, 45'h500);
            else if (k >= 7 && k <= 10) exp_pkt = pkt(3'(k-6), 45'(32'h500 + k - 6));
            else                        exp_pkt = '0;
            chk("full_dout", 64'(dout_leaf), 64'(exp_pkt));
            if (k == 6) chk("full_retry", 64'(tx_retry_cnt), 64'd4);
            tick();
        end

        // ---- retry counter saturation and clear priority ----
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        s_valid = 1'b1; s_dest = 3'd1; s_payload = 45'h77;
        tick();
        s_valid = 1'b0; resend = 1'b1;
        repeat (65540) tick();
        chk("sat_retry", 64'(tx_retry_cnt), 64'hFFFF);
        chk("sat_dout", 64'(dout_leaf), 64'(pkt(3'd1, 45'h77)));
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("sat_clr", 64'(tx_retry_cnt), 64'd0);
        tick();
        chk("sat_inc1", 64'(tx_retry_cnt), 64'd1);
        resend = 1'b0;
        tick();
        chk("sat_dout0", 64'(dout_leaf), 64'd0);
        chk("sat_cnt1", 64'(tx_retry_cnt), 64'd1);

        // ---- RX overflow: 5 packets, 4 kept ----
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din_leaf = {1'b1, 3'(k), 45'(k + 1)};
            if (k == 0) chk("rx_mvalid0", 64'(m_valid), 64'd0);
            if (k == 4) chk("rx_ovf0", 64'(rx_overflow), 64'd0);
            tick();
        end
        din_leaf = {1'b0, 3'd3, 45'h3333};   // invalid: must not be stored
        chk("rx_ovf1", 64'(rx_overflow), 64'd1);
        for (int j = 0; j < 4; j++) begin
            m_ready = 1'b1;
            chk("rx_drain_v", 64'(m_valid), 64'd1);
            chk("rx_drain_p", 64'(m_payload), 64'(j + 1));
            tick();
            din_leaf = '0;
        end
        chk("rx_empty", 64'(m_valid), 64'd0);
        m_ready = 1'b0;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("rx_ovf_clr", 64'(rx_overflow), 64'd0);

        // ---- RX full with same-cycle pop accepts the packet ----
        for (int k = 0; k < 5; k++) begin
            din_leaf = {1'b1, 3'd0, 45'(32'h11 + k)};
            m_ready  = (k == 4);
            if (k == 4) chk("rxfp_head", 64'(m_payload), 64'h11);
            tick();
        end
        din_leaf = '0;
        for (int j = 0; j < 4; j++) begin
            chk("rxfp_p", 64'(m_payload), 64'(32'h12 + j));
            tick();
        end
        chk("rxfp_empty", 64'(m_valid), 64'd0);
        chk("rxfp_ovf", 64'(rx_overflow), 64'd0);

        // ---- clear_stats wins over a same-cycle overflow ----
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din_leaf    = {1'b1, 3'd0, 45'(32'h21 + k)};
            clear_stats = (k == 4);
            tick();
        end
        din_leaf = '0; clear_stats = 1'b0;
        chk("clrwin_ovf", 64'(rx_overflow), 64'd0);
        m_ready = 1'b1;
        repeat (4) tick();
        chk("clrwin_drop", 64'(m_valid), 64'd0);
        m_ready = 1'b0;

        // ---- reset mid-transfer discards everything ----
        resend = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_dest = 3'(k); s_payload = 45'(k);
            din_leaf = {1'b1, 3'd0, 45'(k)};
            tick();
        end
        s_valid = 1'b0; din_leaf = '0;
        reset = 1'b0;
        #1;
        chk("mrst_dout", 64'(dout_leaf), 64'd0);
        chk("mrst_mvalid", 64'(m_valid), 64'd0);
        tick();
        reset = 1'b1; resend = 1'b0;
        tick();
        tick();
        chk("mrst_dout2", 64'(dout_leaf), 64'd0);
        chk("mrst_ready", 64'(s_ready), 64'd1);
        chk("mrst_mvalid2", 64'(m_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
